// File: rtl/coke_vend_ctrl.sv
// Coin-operated vending controller: accumulates 5/10/25c coins, releases the item
// once credit reaches PRICE, returns change or a refund, and times dispense by tick pulses.
module coke_vend_ctrl #(
    parameter int unsigned PRICE          = 50,
    parameter int unsigned DISPENSE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       cancel,
    output logic [6:0] credit,
    output logic       dispense,
    output logic       change_valid,
    output logic [6:0] change_amt,
    output logic       coin_reject,
    output logic       busy
);

    localparam int unsigned CntW   = $clog2(DISPENSE_TICKS + 1);
    localparam logic [6:0]  PriceC = 7'(PRICE);
    localparam logic [CntW-1:0] TicksC = CntW'(DISPENSE_TICKS);

    typedef enum logic [1:0] {StIdle, StCollect, StDispense} state_e;

    state_e          state_q, state_d;
    logic [6:0]      credit_q, credit_d;
    logic [6:0]      amt_q, amt_d;
    logic            chv_q, chv_d;
    logic            rej_q, rej_d;
    logic            disp_q, disp_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [6:0]      coin_val;
    logic            coin_ok;
    logic [6:0]      sum;
    logic [CntW-1:0] cnt_inc;

    always_comb begin
        coin_val = 7'd0;
        unique case (coin_type)
            2'b01:   coin_val = 7'd5;
            2'b10:   coin_val = 7'd10;
            2'b11:   coin_val = 7'd25;
            default: coin_val = 7'd0;
        endcase
    end

    assign coin_ok = coin_valid && (coin_type != 2'b00);
    // Invalid or absent coins contribute zero, so sum doubles as the refundable credit.
    assign sum     = credit_q + (coin_ok ? coin_val : 7'd0);
    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        amt_d    = amt_q;
        chv_d    = 1'b0;
        rej_d    = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle, StCollect: begin
                rej_d = coin_valid && (coin_type == 2'b00);
                if (coin_ok && sum >= PriceC) begin
                    state_d  = StDispense;
                    credit_d = 7'd0;
                    cnt_d    = '0;
                    if (sum > PriceC) begin
                        chv_d = 1'b1;
                        amt_d = sum - PriceC;
                    end
                end else if (cancel && sum != 7'd0) begin
                    state_d  = StIdle;
                    credit_d = 7'd0;
                    chv_d    = 1'b1;
                    amt_d    = sum;
                end else if (coin_ok) begin
                    state_d  = StCollect;
                    credit_d = sum;
                end
            end
            StDispense: begin
                rej_d = coin_valid;
                if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TicksC) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        disp_d = (state_d == StDispense);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            credit_q <= 7'd0;
            amt_q    <= 7'd0;
            chv_q    <= 1'b0;
            rej_q    <= 1'b0;
            disp_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            amt_q    <= amt_d;
            chv_q    <= chv_d;
            rej_q    <= rej_d;
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
        end
    end

    assign credit       = credit_q;
    assign dispense     = disp_q;
    assign busy         = disp_q;
    assign change_valid = chv_q;
    assign change_amt   = amt_q;
    assign coin_reject  = rej_q;

endmodule

// File: tb/tb_coke_vend_ctrl.sv
// Scoreboard bench for coke_vend_ctrl (PRICE=50, DISPENSE_TICKS=4): directed vectors push
// hand-computed per-cycle expectations; a negedge monitor pops and compares them.
module tb_coke_vend_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       cancel;
    logic [6:0] credit;
    logic       dispense;
    logic       change_valid;
    logic [6:0] change_amt;
    logic       coin_reject;
    logic       busy;

    typedef struct packed {
        logic [6:0] credit;
        logic       disp;
        logic       chv;
        logic [6:0] amt;
        logic       rej;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    coke_vend_ctrl #(
        .PRICE          (50),
        .DISPENSE_TICKS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .cancel       (cancel),
        .credit       (credit),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are registered, so one expectation per clock.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("credit", int'(credit), int'(e.credit));
            check("dispense", int'(dispense), int'(e.disp));
            check("busy", int'(busy), int'(e.disp));
            check("change_valid", int'(change_valid), int'(e.chv));
            check("coin_reject", int'(coin_reject), int'(e.rej));
            if (e.chv) check("change_amt", int'(change_amt), int'(e.amt));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next posedge.
    task automatic step(input logic r, input logic cv, input logic [1:0] ct, input logic cn,
                        input logic tk, input int e_cr, input logic e_d, input logic e_cv,
                        input int e_amt, input logic e_rej);
        exp_t e;
        @(negedge clk);
        #1;
        rst_n      = r;
        coin_valid = cv;
        coin_type  = ct;
        cancel     = cn;
        tick       = tk;
        e.credit   = 7'(e_cr);
        e.disp     = e_d;
        e.chv      = e_cv;
        e.amt      = 7'(e_amt);
        e.rej      = e_rej;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; coin_valid = 1'b0; coin_type = 2'b00; cancel = 1'b0;

        // reset
        step(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2'b11, 1, 1, 0, 0, 0, 0, 0);

        // 25,10,10,5: exact price, no change; entry-cycle tick not counted
        step(1, 1, 2'b11, 0, 0, 25, 0, 0, 0, 0);
        step(1, 1, 2'b10, 0, 0, 35, 0, 0, 0, 0);
        step(1, 1, 2'b10, 0, 0, 45, 0, 0, 0, 0);
        step(1, 1, 2'b01, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 1, 2'b11, 1, 0, 0, 1, 0, 0, 1);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // 25,10,25: change 10; ticks every 7 cycles
        step(1, 1, 2'b11, 0, 0, 25, 0, 0, 0, 0);
        step(1, 1, 2'b10, 0, 0, 35, 0, 0, 0, 0);
        step(1, 1, 2'b11, 0, 0, 0, 1, 1, 10, 0);
        for (int k = 1; k <= 4; k++) begin
            repeat (6) step(1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
            step(1, 0, 2'b00, 0, 1, 0, logic'(k < 4), 0, 0, 0);
        end

        // credit 35, coin 10 + cancel: full refund of 45
        step(1, 1, 2'b11, 0, 0, 25, 0, 0, 0, 0);
        step(1, 1, 2'b10, 0, 0, 35, 0, 0, 0, 0);
        step(1, 1, 2'b10, 1, 0, 0, 0, 1, 45, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // credit 35, coin 25 + cancel: purchase wins, change 10
        step(1, 1, 2'b11, 0, 0, 25, 0, 0, 0, 0);
        step(1, 1, 2'b10, 0, 0, 35, 0, 0, 0, 0);
        step(1, 1, 2'b11, 1, 0, 0, 1, 1, 10, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0);

        // invalid coin at credit 20, then cancel refunds 20
        step(1, 1, 2'b10, 0, 0, 10, 0, 0, 0, 0);
        step(1, 1, 2'b10, 0, 0, 20, 0, 0, 0, 0);
        step(1, 1, 2'b00, 0, 0, 20, 0, 0, 0, 1);
        step(1, 0, 2'b00, 0, 0, 20, 0, 0, 0, 0);
        step(1, 0, 2'b00, 1, 0, 0, 0, 1, 20, 0);
        // cancel / invalid coin / tick in IDLE with zero credit
        step(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        // invalid coin + cancel in COLLECT: reject and refund together
        step(1, 1, 2'b01, 0, 0, 5, 0, 0, 0, 0);
        step(1, 1, 2'b00, 1, 0, 0, 0, 1, 5, 1);
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // reset after 2 ticks of DISPENSE; next purchase needs all 4 ticks
        step(1, 1, 2'b11, 0, 0, 25, 0, 0, 0, 0);
        step(1, 1, 2'b11, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 2'b11, 0, 0, 25, 0, 0, 0, 0);
        step(1, 1, 2'b11, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        coin_valid = 1'b0; cancel = 1'b0; tick = 1'b0; coin_type = 2'b00;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coke_vend_ctrl.md
COKE_VEND_CTRL -- requirements
Module: coke_vend_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 50, item price in cents; legal range 5..100, multiple of 5.
REQ-002 SHALL have parameter DISPENSE_TICKS, default 4, number of tick pulses dispense is held.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 tick  input  1  one-clk-wide enable pulse from the upstream slow-clock stage; timing base for dispense.
REQ-006 coin_valid  input  1  one-cycle strobe: coin present this cycle.
REQ-007 coin_type  input  2  01=5c, 10=10c, 11=25c, 00=invalid coin.
REQ-008 cancel  input  1  one-cycle strobe: customer requests refund.
REQ-009 credit  output  7  accumulated credit in cents (registered).
REQ-010 dispense  output  1  high while the item is being released.
REQ-011 change_valid  output  1  one-cycle strobe qualifying change_amt.
REQ-012 change_amt  output  7  cents to return; held until next change_valid.
REQ-013 coin_reject  output  1  one-cycle strobe: coin not accepted.
REQ-014 busy  output  1  high in DISPENSE state.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DISPENSE; state, credit and all outputs registered.
REQ-016 Accepted coin at cycle N SHALL appear in credit at cycle N+1; sum = credit + coin value, 7-bit, no overflow possible (max PRICE-5+25 = 120).
REQ-017 IDLE: valid coin -> COLLECT with credit = coin value, unless coin value >= PRICE (then REQ-018 applies).
REQ-018 IDLE/COLLECT: if sum >= PRICE -> DISPENSE next cycle; credit = 0; change_amt = sum - PRICE; change_valid = 1 for one cycle only if sum > PRICE.
REQ-019 COLLECT: sum < PRICE -> stay COLLECT, credit = sum.
REQ-020 COLLECT: cancel without coin -> IDLE; change_amt = credit, change_valid = 1, credit = 0.
REQ-021 Simultaneous coin_valid and cancel in IDLE/COLLECT: coin is added first; if sum >= PRICE, purchase wins (REQ-018, cancel ignored); else full refund of sum, -> IDLE.
REQ-022 cancel in IDLE with credit 0: no action, no change_valid.
REQ-023 coin_type 00 with coin_valid: coin_reject = 1 next cycle, credit unchanged, state unchanged (cancel in same cycle still honoured).
REQ-024 Any coin_valid in DISPENSE: coin_reject = 1 next cycle, coin discarded; cancel ignored in DISPENSE.
REQ-025 DISPENSE: dispense = 1, busy = 1; internal counter cleared on entry, incremented on each tick; on the tick making count == DISPENSE_TICKS -> IDLE next cycle, dispense = 0.
REQ-026 tick asserted in the same cycle as DISPENSE entry SHALL not be counted.
REQ-027 tick outside DISPENSE SHALL have no effect.
REQ-028 dispense SHALL never be asserted outside DISPENSE; change_valid and coin_reject SHALL never exceed one cycle per event.

Reset
REQ-029 rst_n low at posedge clk: state = IDLE, credit = 0, change_amt = 0, dispense = 0, change_valid = 0, coin_reject = 0, busy = 0, tick counter = 0.
REQ-030 Reset mid-DISPENSE or mid-COLLECT SHALL abort immediately: no refund pulse, credit lost; inputs in the reset cycle ignored.

Verification
REQ-031 PRICE=50: coins 25,10,10,5 on separate cycles -> credit 25,35,45 then DISPENSE, credit 0, change_valid not asserted.
REQ-032 PRICE=50: coins 25,10,25 -> DISPENSE, change_valid one cycle with change_amt = 10.
REQ-033 Credit 35, coin 10 and cancel same cycle -> IDLE, change_amt = 45, change_valid one cycle, no dispense; credit 35, coin 25 + cancel -> DISPENSE, change_amt = 10.
REQ-034 DISPENSE_TICKS=4: enter DISPENSE, ticks every 7 cycles -> dispense high until cycle after 4th tick; coin during DISPENSE -> coin_reject, credit stays 0.
REQ-035 coin_type 00 strobe in COLLECT at credit 20 -> coin_reject one cycle, credit 20; cancel in IDLE -> no outputs change.
REQ-036 rst_n low during DISPENSE after 2 ticks -> all outputs at reset values next cycle; fresh purchase afterwards requires full DISPENSE_TICKS ticks.
